// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: FSM states, parity
// modes and the parity-bit function.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Payload arrives zero-extended to the widest legal frame; zeros leave the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: parity_bit = p;
      PAR_ODD:  parity_bit = ~p;
      default:  parity_bit = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Producer-to-transmitter word handshake (valid/ready plus payload).
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while not cleared and flags
// the last cycle of every bit with a one-cycle bit_done pulse.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic bit_done_o
);
  localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  ZERO = {CW{1'b0}};

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = ZERO;
    end else if (cnt_q == LAST) begin
      cnt_d = ZERO;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches one word per handshake and shifts out
// start, LSB-first data, optional parity and stop bits from a registered line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  uart_tx_serializer_if.slave  tx_if,
  output logic                 tx_o,
  output logic                 busy_o
);
  localparam int              BW        = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]   BIT_ZERO  = {BW{1'b0}};
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, busy_q;
  logic                 accept_s, bit_done_s, baud_clr_s;

  assign accept_s   = tx_if.tx_valid && ready_q;
  assign baud_clr_s = (state_q == IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (baud_clr_s),
    .bit_done_o (bit_done_s)
  );

  // tx_d is the level of the *next* cycle, so the line comes straight from tx_q.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept_s) begin
          state_d = START;
          shift_d = tx_if.tx_data;
          par_d   = parity_bit(9'(tx_if.tx_data), PARITY);
          bit_d   = BIT_ZERO;
          stop_d  = 1'b0;
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_d   = BIT_ZERO;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          if (bit_q == LAST_BIT) begin
            if (PARITY != PAR_NONE) begin
              state_d = uart_pkg::PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end else begin
          state_d = DATA;
        end
      end
      uart_pkg::PARITY: begin
        if (bit_done_s) begin
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          state_d = uart_pkg::PARITY;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_done_s) begin
          if (stop_q == LAST_STOP) begin
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= {DATA_BITS{1'b0}};
      bit_q   <= BIT_ZERO;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign tx_o           = tx_q;
  assign busy_o         = busy_q;
  assign tx_if.tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: 8N1, 8E1 and 8O1 instances share
// one stimulus driver; a line monitor decodes frames and pops expected levels.
module tb_uart_tx_serializer;

  localparam int CPB = 234;

  typedef struct {
    logic [10:0] lvl;
    int          n;
    int          gap;
    int          id;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] drv_data;
  logic       drv_valid;
  int         sel;
  logic       mon_en;
  logic       mon_busy;
  int         total;
  int         bad;
  int         cyc;

  logic tx_n, tx_e, tx_o;
  logic busy_n, busy_e, busy_o;
  logic mon_tx, cur_ready, cur_busy;

  exp_t exp_q[$];

  uart_tx_serializer_if #(.DATA_BITS(8)) if_n ();
  uart_tx_serializer_if #(.DATA_BITS(8)) if_e ();
  uart_tx_serializer_if #(.DATA_BITS(8)) if_o ();

  assign if_n.tx_data  = drv_data;
  assign if_e.tx_data  = drv_data;
  assign if_o.tx_data  = drv_data;
  assign if_n.tx_valid = drv_valid && (sel == 0);
  assign if_e.tx_valid = drv_valid && (sel == 1);
  assign if_o.tx_valid = drv_valid && (sel == 2);

  assign mon_tx    = (sel == 0) ? tx_n : (sel == 1) ? tx_e : tx_o;
  assign cur_busy  = (sel == 0) ? busy_n : (sel == 1) ? busy_e : busy_o;
  assign cur_ready = (sel == 0) ? if_n.tx_ready : (sel == 1) ? if_e.tx_ready : if_o.tx_ready;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk_i(clk), .rst_i(rst), .tx_if(if_n), .tx_o(tx_n), .busy_o(busy_n));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk_i(clk), .rst_i(rst), .tx_if(if_e), .tx_o(tx_e), .busy_o(busy_e));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o (
    .clk_i(clk), .rst_i(rst), .tx_if(if_o), .tx_o(tx_o), .busy_o(busy_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [10:0] lvl, input int n, input int gap, input int id);
    exp_t e;
    e.lvl = lvl;
    e.n   = n;
    e.gap = gap;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  task automatic accept(input logic [7:0] d, input bit hold);
    int n;
    @(negedge clk);
    drv_data  = d;
    drv_valid = 1'b1;
    n = 0;
    while (!cur_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(cur_ready), 32'd1);
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      drv_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cur_ready && lat < 10000);
  endtask

  // Line monitor: a low level while idle marks a start bit; every cycle of every bit is checked.
  exp_t     me;
  logic [10:0] obs, expm;
  int       glitch;
  int       last_start;

  always begin
    @(negedge clk);
    if (mon_en && mon_tx === 1'b0) begin
      mon_busy = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
        repeat (11 * CPB) @(negedge clk);
      end else begin
        me = exp_q.pop_front();
        if (me.gap != 0) check($sformatf("frame%0d_start_gap", me.id), 32'(cyc - last_start), 32'(me.gap));
        last_start = cyc;
        obs = 11'd0;
        expm = 11'd0;
        glitch = 0;
        for (int i = 0; i < me.n; i++) begin
          expm[i] = me.lvl[i];
          for (int j = 0; j < CPB; j++) begin
            if (i > 0 || j > 0) @(negedge clk);
            if (mon_tx !== me.lvl[i]) glitch++;
            if (j == CPB / 2) obs[i] = mon_tx;
          end
        end
        check($sformatf("frame%0d_bits", me.id), 32'(obs), 32'(expm));
        check($sformatf("frame%0d_bad_cycles", me.id), 32'(glitch), 32'd0);
      end
      mon_busy = 1'b0;
    end
  end

  initial begin
    int lat;
    int idle_bad;
    int n;
    total = 0; bad = 0; cyc = 0; last_start = 0;
    rst = 1'b1; drv_valid = 1'b0; drv_data = 8'h00; sel = 0;
    mon_en = 1'b0; mon_busy = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_tx", 32'(tx_n), 32'd1);
    check("reset_ready", 32'(if_n.tx_ready), 32'd1);
    check("reset_busy", 32'(busy_n), 32'd0);
    mon_en = 1'b1;
    idle_bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_n !== 1'b1 || tx_e !== 1'b1 || tx_o !== 1'b1 ||
          if_n.tx_ready !== 1'b1 || if_e.tx_ready !== 1'b1 || if_o.tx_ready !== 1'b1 ||
          busy_n !== 1'b0 || busy_e !== 1'b0 || busy_o !== 1'b0) idle_bad++;
    end
    check("idle_1000_cycles", 32'(idle_bad), 32'd0);

    // 8N1 0x35
    push(11'b0_1_00110101_0, 10, 0, 1);
    accept(8'h35, 1'b0);
    check("8N1_busy_after_accept", 32'(cur_busy), 32'd1);
    wait_ready(lat);
    check("8N1_ready_latency", 32'(lat), 32'd2340);

    // 8E1 and 8O1 0x35: parity 0 then 1
    sel = 1;
    push(11'b1_0_00110101_0, 11, 0, 2);
    accept(8'h35, 1'b0);
    wait_ready(lat);
    check("8E1_ready_latency", 32'(lat), 32'd2574);
    sel = 2;
    push(11'b1_1_00110101_0, 11, 0, 3);
    accept(8'h35, 1'b0);
    wait_ready(lat);
    check("8O1_ready_latency", 32'(lat), 32'd2574);
    sel = 0;
    repeat (5) @(negedge clk);

    // back-to-back 0x41 then 0x00 with valid held
    push(11'b0_1_01000001_0, 10, 0, 4);
    push(11'b0_1_00000000_0, 10, 2341, 5);
    accept(8'h41, 1'b1);
    accept(8'h00, 1'b0);
    wait_ready(lat);
    check("b2b_second_ready_latency", 32'(lat), 32'd2340);

    // payload changed right after acceptance must not leak into the frame
    push(11'b0_1_01000001_0, 10, 0, 6);
    accept(8'h41, 1'b0);
    drv_data = 8'hFF;
    wait_ready(lat);
    check("latch_ready_latency", 32'(lat), 32'd2340);

    // reset during data bit 3 of 0xAA, then a clean 0x55 frame
    push(11'b0_1_10101010_0, 4, 0, 7);
    accept(8'hAA, 1'b0);
    repeat (4 * CPB + 99) @(negedge clk);
    check("pre_reset_busy", 32'(cur_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midframe_reset_tx", 32'(tx_n), 32'd1);
    check("midframe_reset_ready", 32'(if_n.tx_ready), 32'd1);
    check("midframe_reset_busy", 32'(busy_n), 32'd0);
    repeat (3) @(negedge clk);
    push(11'b0_1_01010101_0, 10, 0, 8);
    accept(8'h55, 1'b0);
    wait_ready(lat);
    check("post_reset_ready_latency", 32'(lat), 32'd2340);

    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
